// File: rtl/outfifo_pkg.sv
// Shared types and constants for the output-FIFO burst arbiter.
package outfifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY0 = 2'd1,
      ST_BUSY1 = 2'd2
   } arb_state_e;

   localparam int DW_DEF  = 16;
   localparam int IDLE_CW = 12;

   function automatic logic [1:0] state_to_grant(input arb_state_e s);
      logic [1:0] g;
      case (s)
         ST_BUSY0: g = 2'b01;
         ST_BUSY1: g = 2'b10;
         default:  g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/outfifo_arb_pick.sv
// Two-way round-robin picker: on contention the requester that did not own the last grant wins.
module outfifo_arb_pick
(
   input  logic valid0,
   input  logic valid1,
   input  logic last_gnt,
   output logic pick,
   output logic any
);

   // Select requester index; pick is meaningful only when any is set.
   always_comb begin
      pick = 1'b0;
      any  = valid0 | valid1;
      if (valid0 && valid1) begin
         pick = ~last_gnt;
      end else if (valid1) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
   end

endmodule

// File: rtl/outfifo_burst_arb.sv
// Burst arbiter sharing the output-FIFO write port between two producers.
// Optional idle-timeout abort is enabled by defining OUTFIFO_BURST_ARB_TIMEOUT_EN.
module outfifo_burst_arb
   import outfifo_pkg::*;
#(
   parameter int DW        = DW_DEF,
   parameter int BURST_LEN = 640,
   parameter int CW        = 10,
   parameter int TIMEOUT   = 256
)
(
   input  logic          clk_108m,
   input  logic          rst,
   input  logic          req0_valid,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   input  logic          fifo_afull,
   output logic          out_fifo_wren,
   output logic [DW-1:0] out_fifo_wdata,
   output logic [1:0]    grant,
   output logic          burst_done,
   output logic          burst_abort
);

   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   // Out-of-range parameters elaborate a named marker block visible in synthesis reports.
   if (BURST_LEN < 1 || BURST_LEN > (1 << CW) || TIMEOUT < 1 || TIMEOUT > (1 << IDLE_CW))
   begin : g_param_out_of_range
   end

   arb_state_e    state_q, state_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic          last_gnt_q, last_gnt_d;
   logic          wren_q;
   logic [DW-1:0] wdata_q;

   logic          busy_s, own_s, sel_valid_s, ready_s, beat_s, last_beat_s;
   logic [DW-1:0] sel_data_s;
   logic          pick_s, any_s, timeout_hit_s, abort_s;

   outfifo_arb_pick u_pick (
      .valid0   (req0_valid),
      .valid1   (req1_valid),
      .last_gnt (last_gnt_q),
      .pick     (pick_s),
      .any      (any_s)
   );

   // Route the owning requester onto the shared beat path.
   always_comb begin
      busy_s      = 1'b0;
      own_s       = 1'b0;
      sel_valid_s = 1'b0;
      sel_data_s  = '0;
      case (state_q)
         ST_BUSY0: begin
            busy_s      = 1'b1;
            own_s       = 1'b0;
            sel_valid_s = req0_valid;
            sel_data_s  = req0_data;
         end
         ST_BUSY1: begin
            busy_s      = 1'b1;
            own_s       = 1'b1;
            sel_valid_s = req1_valid;
            sel_data_s  = req1_data;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Ready tracks afull directly; the output register holds the one write already in flight.
   assign ready_s     = busy_s & ~fifo_afull;
   assign beat_s      = sel_valid_s & ready_s;
   assign last_beat_s = beat_s & (beat_cnt_q == LAST_BEAT);

`ifdef OUTFIFO_BURST_ARB_TIMEOUT_EN
   localparam logic [IDLE_CW-1:0] IDLE_LIMIT = IDLE_CW'(TIMEOUT - 1);

   logic [IDLE_CW-1:0] idle_cnt_q, idle_cnt_d;
   logic               idle_tick_s;

   assign idle_tick_s   = busy_s & ~sel_valid_s & ~fifo_afull;
   assign timeout_hit_s = idle_tick_s & (idle_cnt_q == IDLE_LIMIT);

   // Idle watchdog: counts owner-silent cycles, cleared by beats, grants and aborts.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (!busy_s || beat_s || timeout_hit_s) begin
         idle_cnt_d = '0;
      end else if (idle_tick_s) begin
         idle_cnt_d = idle_cnt_q + IDLE_CW'(1);
      end else begin
         idle_cnt_d = idle_cnt_q;
      end
   end

   // Idle counter register.
   always_ff @(posedge clk_108m or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

   // Next-state logic: arbitrate in IDLE, count beats while busy.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      last_gnt_d = last_gnt_q;
      abort_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_afull && any_s) begin
               state_d    = pick_s ? ST_BUSY1 : ST_BUSY0;
               beat_cnt_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY0, ST_BUSY1: begin
            if (last_beat_s) begin
               state_d    = ST_IDLE;
               beat_cnt_d = '0;
               last_gnt_d = own_s;
            end else if (beat_s) begin
               beat_cnt_d = beat_cnt_q + CW'(1);
            end else if (timeout_hit_s) begin
               state_d    = ST_IDLE;
               beat_cnt_d = '0;
               last_gnt_d = own_s;
               abort_s    = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
         end
      endcase
   end

   // State, beat counter and round-robin history.
   always_ff @(posedge clk_108m or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // Output write register; data holds through no-beat cycles.
   always_ff @(posedge clk_108m or posedge rst) begin
      if (rst) begin
         wren_q  <= 1'b0;
         wdata_q <= '0;
      end else begin
         wren_q <= beat_s;
         if (beat_s) begin
            wdata_q <= sel_data_s;
         end
      end
   end

   assign req0_ready     = ready_s & (state_q == ST_BUSY0);
   assign req1_ready     = ready_s & (state_q == ST_BUSY1);
   assign out_fifo_wren  = wren_q;
   assign out_fifo_wdata = wdata_q;
   assign grant          = state_to_grant(state_q);
   assign burst_done     = last_beat_s;
   assign burst_abort    = abort_s;

endmodule

// File: tb/tb_outfifo_burst_arb.sv
// Directed bench for outfifo_burst_arb (BURST_LEN=4, TIMEOUT=8) plus a BURST_LEN=1 instance.
module tb_outfifo_burst_arb;

   logic        clk_108m = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0, fifo_afull = 1'b0;
   logic [15:0] req0_data = 16'h0000, req1_data = 16'h0000;
   logic        req0_ready, req1_ready, out_fifo_wren, burst_done, burst_abort;
   logic [15:0] out_fifo_wdata;
   logic [1:0]  grant;

   logic        b_ready0, b_ready1, b_wren, b_done, b_abort;
   logic [15:0] b_wdata;
   logic [1:0]  b_grant;

   int n_checks = 0;
   int n_errors = 0;

   int          cyc, n0, n1, af_from, af_to;
   logic [15:0] d0, d1;
   logic [1:0]  gl [64];
   logic        r0l [64], r1l [64], dnl [64], abl [64];
   logic [1:0]  bgl [64];
   logic        bwl [64], bdl [64], bal [64], br0l [64], br1l [64];
   logic [15:0] bwdl [64];
   logic [15:0] wq [$];
   logic [15:0] exp_q [$];

   always #5 clk_108m = ~clk_108m;

   outfifo_burst_arb #(.DW(16), .BURST_LEN(4), .CW(10), .TIMEOUT(8)) u_dut (
      .clk_108m(clk_108m), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .fifo_afull(fifo_afull), .out_fifo_wren(out_fifo_wren), .out_fifo_wdata(out_fifo_wdata),
      .grant(grant), .burst_done(burst_done), .burst_abort(burst_abort)
   );

   outfifo_burst_arb #(.DW(16), .BURST_LEN(1), .CW(10), .TIMEOUT(8)) u_dut_len1 (
      .clk_108m(clk_108m), .rst(rst),
      .req0_valid(1'b1), .req0_data(16'hA0A0), .req0_ready(b_ready0),
      .req1_valid(1'b1), .req1_data(16'hB0B1), .req1_ready(b_ready1),
      .fifo_afull(1'b0), .out_fifo_wren(b_wren), .out_fifo_wdata(b_wdata),
      .grant(b_grant), .burst_done(b_done), .burst_abort(b_abort)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      req0_valid = (n0 > 0);
      req0_data  = d0;
      req1_valid = (n1 > 0);
      req1_data  = d1;
      fifo_afull = (cyc >= af_from) && (cyc < af_to);
   endtask

   // One clock cycle: sample settled outputs, then advance producers at the next negedge.
   task automatic step();
      logic a0, a1;
      #1;
      gl[cyc] = grant;      r0l[cyc] = req0_ready; r1l[cyc] = req1_ready;
      dnl[cyc] = burst_done; abl[cyc] = burst_abort;
      bgl[cyc] = b_grant;   bwl[cyc] = b_wren;     bwdl[cyc] = b_wdata;
      bdl[cyc] = b_done;    bal[cyc] = b_abort;    br0l[cyc] = b_ready0; br1l[cyc] = b_ready1;
      if (out_fifo_wren) wq.push_back(out_fifo_wdata);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      @(negedge clk_108m);
      if (a0) begin d0 = d0 + 16'd1; n0--; end
      if (a1) begin d1 = d1 + 16'd1; n1--; end
      cyc++;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      n0 = 0; n1 = 0; af_from = 0; af_to = 0; cyc = 0;
      drive();
      repeat (2) @(negedge clk_108m);
      #1;
      check_eq("rst_wren",  {31'd0, out_fifo_wren}, 32'd0);
      check_eq("rst_wdata", {16'd0, out_fifo_wdata}, 32'd0);
      check_eq("rst_grant", {30'd0, grant}, 32'd0);
      check_eq("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      check_eq("rst_pulse", {30'd0, burst_done, burst_abort}, 32'd0);
      @(negedge clk_108m);
      rst = 1'b0;
      wq.delete();
   endtask

   task automatic check_writes(input string tag);
      check_eq({tag, "_count"}, wq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
         check_eq(tag, {16'd0, wq[i]}, {16'd0, exp_q[i]});
   endtask

   initial begin
      // Single requester burst.
      do_reset();
      n0 = 4; d0 = 16'h1100; drive();
      repeat (7) step();
      check_eq("t1_grant_c0", {30'd0, gl[0]}, 32'd0);
      check_eq("t1_ready_c0", {31'd0, r0l[0]}, 32'd0);
      for (int c = 1; c <= 4; c++) check_eq("t1_grant_busy", {30'd0, gl[c]}, 32'd1);
      check_eq("t1_done_c3", {31'd0, dnl[3]}, 32'd0);
      check_eq("t1_done_c4", {31'd0, dnl[4]}, 32'd1);
      check_eq("t1_grant_c5", {30'd0, gl[5]}, 32'd0);
      exp_q = '{16'h1100, 16'h1101, 16'h1102, 16'h1103};
      check_writes("t1_wdata");

      // Both requesters continuous: alternating bursts with one idle cycle between.
      do_reset();
      n0 = 8; d0 = 16'h2000; n1 = 8; d1 = 16'h3000; drive();
      repeat (22) step();
      for (int c = 0; c <= 20; c++) begin
         logic [1:0] eg;
         if (c == 20 || (c % 5) == 0) eg = 2'b00;
         else if (((c / 5) % 2) == 0) eg = 2'b01;
         else eg = 2'b10;
         check_eq($sformatf("t2_grant_c%0d", c), {30'd0, gl[c]}, {30'd0, eg});
      end
      check_eq("t2_done", {28'd0, dnl[4], dnl[9], dnl[14], dnl[19]}, 32'hF);
      exp_q = '{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h3000, 16'h3001, 16'h3002, 16'h3003,
                16'h2004, 16'h2005, 16'h2006, 16'h2007, 16'h3004, 16'h3005, 16'h3006, 16'h3007};
      check_writes("t2_wdata");

      // Almost-full stall for 5 cycles after the second beat.
      do_reset();
      n0 = 4; d0 = 16'h4000; af_from = 3; af_to = 8; drive();
      repeat (11) step();
      for (int c = 3; c <= 7; c++) begin
         check_eq("t3_ready_stall", {31'd0, r0l[c]}, 32'd0);
         check_eq("t3_grant_stall", {30'd0, gl[c]}, 32'd1);
      end
      check_eq("t3_done_c9", {31'd0, dnl[9]}, 32'd1);
      exp_q = '{16'h4000, 16'h4001, 16'h4002, 16'h4003};
      check_writes("t3_wdata");

      // Reset mid-burst of requester 1; requester 0 is served first afterwards.
      do_reset();
      n1 = 4; d1 = 16'h5000; drive();
      repeat (3) step();
      rst = 1'b1;
      #1;
      check_eq("t4_rst_wren",  {31'd0, out_fifo_wren}, 32'd0);
      check_eq("t4_rst_wdata", {16'd0, out_fifo_wdata}, 32'd0);
      check_eq("t4_rst_grant", {30'd0, grant}, 32'd0);
      check_eq("t4_rst_ready", {31'd0, req1_ready}, 32'd0);
      n0 = 2; d0 = 16'h6000;
      @(negedge clk_108m);
      rst = 1'b0; cyc = 0; drive();
      repeat (3) step();
      check_eq("t4_grant_c0", {30'd0, gl[0]}, 32'd0);
      check_eq("t4_grant_c1", {30'd0, gl[1]}, 32'd1);
      check_eq("t4_ready1_c1", {31'd0, r1l[1]}, 32'd0);

      // Owner goes silent after two beats while requester 1 waits.
      do_reset();
      n0 = 2; d0 = 16'h7000; n1 = 1; d1 = 16'h8000; drive();
      repeat (14) step();
      check_eq("t5_grant_c1", {30'd0, gl[1]}, 32'd1);
`ifdef OUTFIFO_BURST_ARB_TIMEOUT_EN
      check_eq("t5_abort_c9",  {31'd0, abl[9]}, 32'd0);
      check_eq("t5_abort_c10", {31'd0, abl[10]}, 32'd1);
      check_eq("t5_grant_c10", {30'd0, gl[10]}, 32'd1);
      check_eq("t5_grant_c11", {30'd0, gl[11]}, 32'd0);
      check_eq("t5_grant_c12", {30'd0, gl[12]}, 32'd2);
`else
      for (int c = 3; c <= 13; c++) begin
         check_eq("t5_grant_held", {30'd0, gl[c]}, 32'd1);
         check_eq("t5_no_abort", {31'd0, abl[c]}, 32'd0);
      end
`endif

      // BURST_LEN=1 instance: single-beat grants alternating every two cycles.
      do_reset();
      drive();
      repeat (10) step();
      check_eq("t6_grant_c1", {30'd0, bgl[1]}, 32'd1);
      check_eq("t6_ready0_c1", {31'd0, br0l[1]}, 32'd1);
      check_eq("t6_done_c1", {31'd0, bdl[1]}, 32'd1);
      check_eq("t6_grant_c3", {30'd0, bgl[3]}, 32'd2);
      check_eq("t6_ready1_c3", {31'd0, br1l[3]}, 32'd1);
      check_eq("t6_abort", {31'd0, bal[3]}, 32'd0);
      for (int c = 2; c <= 9; c++) begin
         check_eq($sformatf("t6_wren_c%0d", c), {31'd0, bwl[c]}, {31'd0, (c % 2) == 0});
         if ((c % 2) == 0)
            check_eq($sformatf("t6_wdata_c%0d", c), {16'd0, bwdl[c]},
                     ((c % 4) == 2) ? 32'h0000A0A0 : 32'h0000B0B1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
